// File: rtl/config_sequencer.sv
// Configuration sequencer: pulls (addr, data) words from the bitstream source and
// broadcasts each one on the tile-array config bus with a one-cycle write strobe.
module config_sequencer #(
    parameter int NUM_TILES   = 16,
    parameter int HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] num_words,
    input  logic        bs_valid,
    input  logic [63:0] bs_data,
    output logic        bs_ready,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        config_valid,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WRITE,
        HOLD,
        DONE
    } state_t;

    localparam logic [16:0] TILE_LIMIT = 17'(NUM_TILES);
    localparam logic [3:0]  HOLD_LOAD  = 4'(HOLD_CYCLES - 1);

    state_t      state;
    logic [15:0] num_words_q;
    logic [3:0]  hold_cnt;
    logic        tile_ok;
    logic [15:0] word_next;

    assign tile_ok   = {1'b0, bs_data[63:48]} < TILE_LIMIT;
    assign word_next = words_done + 16'd1;

    // abort masks ready combinationally so no word is consumed in the abort cycle
    assign bs_ready = (state == FETCH) && !abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            num_words_q  <= '0;
            hold_cnt     <= '0;
            config_addr  <= '0;
            config_data  <= '0;
            config_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_done   <= '0;
        end else begin
            config_valid <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        num_words_q <= num_words;
                        words_done  <= '0;
                        error       <= 1'b0;
                        busy        <= 1'b1;
                        if (num_words == 16'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        case (state)
                            FETCH: begin
                                if (bs_valid) begin
                                    if (words_done < num_words_q) begin
                                        words_done <= word_next;
                                    end
                                    if (tile_ok) begin
                                        // bus is loaded on the edge entering WRITE, so it changes only there
                                        config_addr  <= bs_data[63:32];
                                        config_data  <= bs_data[31:0];
                                        config_valid <= 1'b1;
                                        state        <= WRITE;
                                    end else begin
                                        error <= 1'b1;
                                        if (word_next < num_words_q) begin
                                            state <= FETCH;
                                        end else begin
                                            state <= DONE;
                                            done  <= 1'b1;
                                        end
                                    end
                                end
                            end
                            WRITE: begin
                                hold_cnt <= HOLD_LOAD;
                                state    <= HOLD;
                            end
                            HOLD: begin
                                if (hold_cnt == 4'd0) begin
                                    if (words_done < num_words_q) begin
                                        state <= FETCH;
                                    end else begin
                                        state <= DONE;
                                        done  <= 1'b1;
                                    end
                                end else begin
                                    hold_cnt <= hold_cnt - 4'd1;
                                end
                            end
                            DONE: begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_sequencer.sv
// Directed self-checking bench for config_sequencer (NUM_TILES=16, HOLD_CYCLES=2).
module tb_config_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] num_words = '0;
    logic        bs_valid = 1'b0;
    logic [63:0] bs_data = '0;
    logic        bs_ready;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        config_valid;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_done;

    config_sequencer #(.NUM_TILES(16), .HOLD_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .num_words(num_words),
        .bs_valid(bs_valid), .bs_data(bs_data), .bs_ready(bs_ready),
        .config_addr(config_addr), .config_data(config_data), .config_valid(config_valid),
        .busy(busy), .done(done), .error(error), .words_done(words_done)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fails = 0;

    logic [63:0] words [0:3];
    int          strobe_cyc [0:7];
    logic [31:0] strobe_addr [0:7];
    logic [31:0] strobe_data [0:7];
    int          n_strobe, done_cyc, done_cnt, ready_cnt, bus_changes, end_cyc;
    logic        timed_out;
    logic [15:0] wd_c1;
    logic        err_c1;

    // Runs one load: start in cycle 0, optional source stall per FETCH visit, optional abort.
    task automatic run_load(input logic [15:0] nw, input int stall, input int abort_cyc, input int max_cyc);
        int idx, fw;
        logic consume;
        logic [31:0] prev_addr, prev_data;
        n_strobe = 0; done_cyc = -1; done_cnt = 0; ready_cnt = 0; bus_changes = 0;
        end_cyc = -1; timed_out = 1'b1; idx = 0; fw = 0;
        @(posedge clk); #1;
        prev_addr = config_addr; prev_data = config_data;
        for (int c = 0; c < max_cyc; c++) begin
            start = (c == 0);
            abort = (c == abort_cyc);
            num_words = nw;
            bs_data = (idx < 4) ? words[idx] : 64'd0;
            #1;
            if (stall == 0) bs_valid = 1'b1;
            else if (bs_ready) begin
                bs_valid = (fw >= stall);
                if (!bs_valid) fw++;
            end else bs_valid = 1'b0;
            #1;
            if (c == 1) begin wd_c1 = words_done; err_c1 = error; end
            if (config_valid) begin
                if (n_strobe < 8) begin
                    strobe_cyc[n_strobe] = c; strobe_addr[n_strobe] = config_addr; strobe_data[n_strobe] = config_data;
                end
                n_strobe++;
            end else if (config_addr !== prev_addr || config_data !== prev_data) bus_changes++;
            prev_addr = config_addr; prev_data = config_data;
            if (done) begin if (done_cnt == 0) done_cyc = c; done_cnt++; end
            if (bs_ready) ready_cnt++;
            consume = bs_valid && bs_ready;
            if (c >= 2 && !busy) begin end_cyc = c; timed_out = 1'b0; break; end
            @(posedge clk); #1;
            if (consume) begin idx++; fw = 0; end
        end
        start = 1'b0; abort = 1'b0; bs_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        tests_run++; if (bs_ready !== 1'b0) begin fails++; $display("FAIL reset_bs_ready: got %b want 0", bs_ready); end
        tests_run++; if (config_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin fails++;
            $display("FAIL reset_flags: got valid=%b busy=%b done=%b error=%b want all 0", config_valid, busy, done, error); end
        tests_run++; if (config_addr !== 32'd0 || config_data !== 32'd0 || words_done !== 16'd0) begin fails++;
            $display("FAIL reset_bus: got addr=%h data=%h wd=%0d want 0", config_addr, config_data, words_done); end
        #1 reset = 1'b1;
    endtask

    task automatic test_nominal();
        words[0] = 64'h0001_0002_DEAD_BEEF;
        words[1] = 64'h0003_0010_1234_5678;
        words[2] = 64'h000F_FFFF_CAFE_F00D;
        words[3] = 64'h0;
        run_load(16'd3, 0, -1, 40);
        tests_run++; if (timed_out !== 1'b0) begin fails++; $display("FAIL nominal_timeout: got %b want 0", timed_out); end
        tests_run++; if (n_strobe !== 3) begin fails++; $display("FAIL nominal_strobes: got %0d want 3", n_strobe); end
        tests_run++; if (strobe_cyc[0] !== 2 || strobe_cyc[1] !== 6 || strobe_cyc[2] !== 10) begin fails++;
            $display("FAIL nominal_strobe_cyc: got %0d,%0d,%0d want 2,6,10", strobe_cyc[0], strobe_cyc[1], strobe_cyc[2]); end
        tests_run++; if (strobe_addr[0] !== 32'h0001_0002 || strobe_data[0] !== 32'hDEAD_BEEF) begin fails++;
            $display("FAIL nominal_word0: got %h/%h want 00010002/deadbeef", strobe_addr[0], strobe_data[0]); end
        tests_run++; if (strobe_addr[2] !== 32'h000F_FFFF || strobe_data[2] !== 32'hCAFE_F00D) begin fails++;
            $display("FAIL nominal_word2_tile15: got %h/%h want 000fffff/cafef00d", strobe_addr[2], strobe_data[2]); end
        tests_run++; if (done_cyc !== 13 || done_cnt !== 1) begin fails++;
            $display("FAIL nominal_done: got cyc=%0d cnt=%0d want 13/1", done_cyc, done_cnt); end
        tests_run++; if (end_cyc !== 14) begin fails++; $display("FAIL nominal_busy_low: got %0d want 14", end_cyc); end
        tests_run++; if (words_done !== 16'd3 || error !== 1'b0) begin fails++;
            $display("FAIL nominal_final: got wd=%0d err=%b want 3/0", words_done, error); end
        tests_run++; if (bus_changes !== 0) begin fails++; $display("FAIL nominal_bus_stable: got %0d want 0", bus_changes); end
        tests_run++; if (config_addr !== 32'h000F_FFFF) begin fails++; $display("FAIL nominal_bus_hold_idle: got %h want 000fffff", config_addr); end
    endtask

    task automatic test_backpressure();
        words[0] = 64'h0004_0001_1111_1111;
        words[1] = 64'h0005_0002_2222_2222;
        words[2] = 64'h0006_0003_3333_3333;
        run_load(16'd3, 5, -1, 60);
        tests_run++; if (n_strobe !== 3 || timed_out !== 1'b0) begin fails++;
            $display("FAIL bp_strobes: got %0d timeout=%b want 3/0", n_strobe, timed_out); end
        tests_run++; if (strobe_cyc[0] !== 7 || strobe_cyc[1] !== 16 || strobe_cyc[2] !== 25) begin fails++;
            $display("FAIL bp_strobe_cyc: got %0d,%0d,%0d want 7,16,25", strobe_cyc[0], strobe_cyc[1], strobe_cyc[2]); end
        tests_run++; if (strobe_data[0] !== 32'h1111_1111 || strobe_data[1] !== 32'h2222_2222 || strobe_data[2] !== 32'h3333_3333) begin fails++;
            $display("FAIL bp_order: got %h,%h,%h want 11111111,22222222,33333333", strobe_data[0], strobe_data[1], strobe_data[2]); end
        tests_run++; if (bus_changes !== 0) begin fails++; $display("FAIL bp_bus_stable: got %0d want 0", bus_changes); end
        tests_run++; if (done_cyc !== 28) begin fails++; $display("FAIL bp_done: got %0d want 28", done_cyc); end
    endtask

    task automatic test_bad_tile();
        words[0] = 64'h0010_0001_AAAA_AAAA;
        words[1] = 64'h0002_0003_5555_5555;
        run_load(16'd2, 0, -1, 40);
        tests_run++; if (n_strobe !== 1 || strobe_cyc[0] !== 3) begin fails++;
            $display("FAIL bad_strobe: got n=%0d cyc=%0d want 1/3", n_strobe, strobe_cyc[0]); end
        tests_run++; if (strobe_addr[0] !== 32'h0002_0003 || strobe_data[0] !== 32'h5555_5555) begin fails++;
            $display("FAIL bad_good_word: got %h/%h want 00020003/55555555", strobe_addr[0], strobe_data[0]); end
        tests_run++; if (bus_changes !== 0) begin fails++; $display("FAIL bad_bus_untouched: got %0d want 0", bus_changes); end
        tests_run++; if (done_cyc !== 6 || end_cyc !== 7) begin fails++;
            $display("FAIL bad_done: got done=%0d end=%0d want 6/7", done_cyc, end_cyc); end
        tests_run++; if (error !== 1'b1 || words_done !== 16'd2) begin fails++;
            $display("FAIL bad_error: got err=%b wd=%0d want 1/2", error, words_done); end
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (error !== 1'b1) begin fails++; $display("FAIL bad_error_sticky: got %b want 1", error); end
    endtask

    task automatic test_zero_words();
        run_load(16'd0, 0, -1, 20);
        tests_run++; if (err_c1 !== 1'b0) begin fails++; $display("FAIL zero_error_cleared: got %b want 0", err_c1); end
        tests_run++; if (done_cyc !== 1 || end_cyc !== 2) begin fails++;
            $display("FAIL zero_done: got done=%0d end=%0d want 1/2", done_cyc, end_cyc); end
        tests_run++; if (ready_cnt !== 0 || n_strobe !== 0) begin fails++;
            $display("FAIL zero_no_traffic: got ready=%0d strobes=%0d want 0/0", ready_cnt, n_strobe); end
    endtask

    task automatic test_abort();
        words[0] = 64'h0001_0001_0000_0001;
        words[1] = 64'h0001_0002_0000_0002;
        words[2] = 64'h0001_0003_0000_0003;
        words[3] = 64'h0001_0004_0000_0004;
        run_load(16'd4, 0, 7, 40);
        tests_run++; if (end_cyc !== 8 || done_cnt !== 0) begin fails++;
            $display("FAIL abort_hold: got end=%0d done_cnt=%0d want 8/0", end_cyc, done_cnt); end
        tests_run++; if (words_done !== 16'd2 || n_strobe !== 2 || ready_cnt !== 2) begin fails++;
            $display("FAIL abort_counts: got wd=%0d strobes=%0d ready=%0d want 2/2/2", words_done, n_strobe, ready_cnt); end
        bs_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests_run++; if (bs_ready !== 1'b0 || words_done !== 16'd2) begin fails++;
                $display("FAIL abort_idle_%0d: got ready=%b wd=%0d want 0/2", i, bs_ready, words_done); end
        end
        bs_valid = 1'b0;
        run_load(16'd2, 0, 1, 20);
        tests_run++; if (wd_c1 !== 16'd0) begin fails++; $display("FAIL abort_restart_wd: got %0d want 0", wd_c1); end
        tests_run++; if (ready_cnt !== 0 || words_done !== 16'd0 || n_strobe !== 0 || end_cyc !== 2) begin fails++;
            $display("FAIL abort_fetch: got ready=%0d wd=%0d strobes=%0d end=%0d want 0/0/0/2", ready_cnt, words_done, n_strobe, end_cyc); end
    endtask

    task automatic test_start_abort_idle();
        words[0] = 64'h0007_0007_7777_7777;
        run_load(16'd1, 0, 0, 20);
        tests_run++; if (n_strobe !== 1 || strobe_cyc[0] !== 2 || done_cyc !== 5 || end_cyc !== 6) begin fails++;
            $display("FAIL start_wins: got n=%0d strobe=%0d done=%0d end=%0d want 1/2/5/6", n_strobe, strobe_cyc[0], done_cyc, end_cyc); end
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        start = 1'b1; num_words = 16'd3; bs_valid = 1'b1; bs_data = 64'h0009_0009_9999_9999;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        tests_run++; if (config_valid !== 1'b1) begin fails++; $display("FAIL arst_in_write: got %b want 1", config_valid); end
        #2 reset = 1'b0;
        #1;
        tests_run++; if (config_valid !== 1'b0 || busy !== 1'b0 || bs_ready !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin fails++;
            $display("FAIL arst_flags: got valid=%b busy=%b ready=%b done=%b err=%b want 0", config_valid, busy, bs_ready, done, error); end
        tests_run++; if (config_addr !== 32'd0 || config_data !== 32'd0 || words_done !== 16'd0) begin fails++;
            $display("FAIL arst_bus: got addr=%h data=%h wd=%0d want 0", config_addr, config_data, words_done); end
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests_run++; if (busy !== 1'b0 || bs_ready !== 1'b0 || config_valid !== 1'b0) begin fails++;
                $display("FAIL arst_idle_%0d: got busy=%b ready=%b valid=%b want 0", i, busy, bs_ready, config_valid); end
        end
        bs_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_bad_tile();
        test_zero_words();
        test_abort();
        test_start_abort_idle();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/config_sequencer.md
# config_sequencer

Configuration sequencer for the tile array. It pulls (address, data) configuration words from a bitstream source over a valid/ready handshake and broadcasts each one on the shared config_addr/config_data bus with a one-cycle write strobe. After each write it holds the bus stable for a programmable settle window, so every tile's address matchers and configuration registers (logic block, connect boxes, switch box) capture the word. It sits above the tile grid and is the only driver of the array's configuration bus.

## Interface
Parameters:
- NUM_TILES, default 16: number of valid tile IDs; legal tile_id range is 0..NUM_TILES-1.
- HOLD_CYCLES, default 2: bus-stable cycles after each strobe; legal range 1..15.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces every register to its reset value immediately.
- start  in  1  one-cycle request to begin a load; ignored unless the block is in IDLE.
- abort  in  1  ends any load in progress.
- num_words  in  16  number of bitstream words to load; sampled on accepted start.
- bs_valid  in  1  bitstream word available.
- bs_data  in  64  [63:32] = config_addr, [31:0] = config_data; config_addr[31:16] = tile_id, [15:0] = config_id.
- bs_ready  out  1  block accepts a word this cycle.
- config_addr  out  32  broadcast address to tiles.
- config_data  out  32  broadcast data to tiles.
- config_valid  out  1  one-cycle write strobe.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a load completes normally.
- error  out  1  sticky; set by an out-of-range tile_id; cleared by the next accepted start.
- words_done  out  16  bitstream words consumed in the current load.

## Operation
- States: IDLE, FETCH, WRITE, HOLD, DONE.
- IDLE:
  - start=1 latches num_words, clears words_done and error.
  - If num_words=0, go to DONE; otherwise go to FETCH.
- FETCH:
  - bs_ready=1.
  - On bs_valid=1, capture bs_data and increment words_done.
  - If the captured tile_id < NUM_TILES, go to WRITE.
  - Otherwise set error, drop the word (no strobe), and go to FETCH if words_done < num_words, else DONE.
- WRITE:
  - config_addr and config_data take the captured word; config_valid=1 for exactly this cycle.
  - Then go to HOLD.
- HOLD:
  - A 4-bit counter counts HOLD_CYCLES cycles; the bus stays stable and config_valid=0.
  - At expiry, go to FETCH if words_done < num_words, else DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; done is not pulsed.
  - bs_ready is forced to 0 in that cycle, so no word is consumed.
  - A strobe already driven is not retracted.
- bs_ready is 0 in every state except FETCH. A word is consumed only when bs_valid and bs_ready are both 1.
- config_addr and config_data hold their last written value between writes and in IDLE; they never change outside WRITE.
- words_done saturates at num_words and holds its value in IDLE until the next start.
- Reset values: state IDLE; bs_ready, config_valid, busy, done and error all 0; config_addr, config_data and words_done all 0.

## Timing
- start at cycle 0: FETCH at 1. If bs_valid=1 at cycle 1, config_valid=1 at cycle 2.
- Minimum per-word period is 2 + HOLD_CYCLES cycles. A rejected word costs 1 cycle.
- Last HOLD cycle at N means done=1 at N+1 and busy=0 at N+2.
- A stalled source (bs_valid=0) keeps the block in FETCH indefinitely, with busy=1 and the bus stable.
- start and abort in the same cycle in IDLE: start wins. In any other state, abort wins and start is ignored.
- An asynchronous reset assertion mid-write drops config_valid combinationally-from-flop at once. The partially loaded array state is the software's responsibility.

## Test plan
- Nominal load, HOLD_CYCLES=2, num_words=3, bs_valid always 1, words 0x0001_0002/0xDEAD_BEEF, etc. -> config_valid pulses at cycles 2, 6 and 10; done=1 at cycle 13; words_done=3; error=0.
- Backpressure: bs_valid low for 5 cycles before each word -> strobes delayed by 5 cycles each; bus unchanged while stalled; data order preserved.
- Bad tile: num_words=2, first word tile_id=NUM_TILES -> no strobe for it; error=1; second word strobed; done pulses; error remains 1 until the next start.
- num_words=0 -> done at cycle 1, no bs_ready and no strobe.
- Abort during HOLD of word 2 of 4 -> IDLE next cycle; no done; words_done=2; no further bs_ready. A new start then restarts with words_done=0.
- Reset (reset=0) asserted asynchronously in WRITE -> all outputs 0 before the next clock edge. After release, the block is in IDLE and ignores bs_valid.
